// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and RV32 width codes for the two-port word-memory arbiter.
// Also holds the helpers that decode an access size and check its alignment.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned codes only exist for loads; every reserved code decodes as a word.
    function automatic size_t access_size(input logic write, input logic [2:0] func3);
        size_t size;
        size = SZ_W;
        if (func3 == F3_B || (!write && func3 == F3_BU)) begin
            size = SZ_B;
        end else if (func3 == F3_H || (!write && func3 == F3_HU)) begin
            size = SZ_H;
        end
        return size;
    endfunction

    function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane handling: extracts and extends load data from a word,
// and builds the read-modify-write word for sub-word stores.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  size_t       size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word[{lane, 3'b000} +: 8];
    assign half_lane = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: defaults first, so no path through the case can infer a latch.
        load_data  = word;
        merge_data = word;
        case (size)
            SZ_B: begin
                load_data = is_unsigned ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
                merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data = is_unsigned ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
                merge_data[{lane[1], 4'b0000} +: 16] = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port RV32 load/store front end onto a single word-wide memory:
// port-0-priority arbitration with starvation relief, one request in flight.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic        p0_req_write,
    input  logic [2:0]  p0_req_func3,
    input  logic [31:0] p0_req_addr,
    input  logic [31:0] p0_req_wdata,
    output logic        p0_resp_valid,
    output logic [31:0] p0_resp_rdata,
    output logic        p0_resp_error,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic        p1_req_write,
    input  logic [2:0]  p1_req_func3,
    input  logic [31:0] p1_req_addr,
    input  logic [31:0] p1_req_wdata,
    output logic        p1_resp_valid,
    output logic [31:0] p1_resp_rdata,
    output logic        p1_resp_error,

    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [2:0]  mem_func3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_t           state, state_next;
    logic [CNT_W-1:0] starve_cnt;

    logic        cur_port;
    logic        cur_write;
    logic        cur_error;
    logic [2:0]  cur_func3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [31:0] cur_word;
    size_t       cur_size;

    logic        grant0, grant1, accept, capture;
    logic        sel_write;
    logic [2:0]  sel_func3;
    logic [31:0] sel_addr, sel_wdata;
    logic [31:0] load_data, merge_data, resp_data;

    // Port 1 wins only when port 0 is idle or has used up its starvation budget.
    assign grant1 = p1_req_valid && (!p0_req_valid || starve_cnt == CNT_MAX);
    assign grant0 = p0_req_valid && !grant1;

    assign p0_req_ready = (state == IDLE) && grant0 && !reset;
    assign p1_req_ready = (state == IDLE) && grant1 && !reset;
    assign accept       = p0_req_ready || p1_req_ready;

    assign sel_write = grant1 ? p1_req_write : p0_req_write;
    assign sel_func3 = grant1 ? p1_req_func3 : p0_req_func3;
    assign sel_addr  = grant1 ? p1_req_addr  : p0_req_addr;
    assign sel_wdata = grant1 ? p1_req_wdata : p0_req_wdata;

    assign cur_size = access_size(cur_write, cur_func3);

    mem_lane_align u_lane_align (
        .size        (cur_size),
        .is_unsigned (cur_func3 == F3_BU || cur_func3 == F3_HU),
        .lane        (cur_addr[1:0]),
        .word        (cur_word),
        .wdata       (cur_wdata[15:0]),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            cur_port   <= 1'b0;
            cur_write  <= 1'b0;
            cur_error  <= 1'b0;
            cur_func3  <= '0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            cur_word   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cur_port  <= grant1;
                cur_write <= sel_write;
                cur_func3 <= sel_func3;
                cur_addr  <= sel_addr;
                cur_wdata <= sel_wdata;
                cur_error <= is_misaligned(access_size(sel_write, sel_func3), sel_addr[1:0]);
            end
            if (capture) begin
                cur_word <= mem_rdata;
            end
            if (!p1_req_valid || p1_req_ready) begin
                starve_cnt <= '0;
            end else if (p0_req_ready && starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next       = state;
        capture          = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_wdata        = '0;
        p0_resp_valid    = 1'b0;
        p1_resp_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (grant0 || grant1) state_next = ACCESS;
            end
            ACCESS: begin
                if (cur_error) begin
                    state_next = RESP;
                end else if (cur_write && cur_size == SZ_W) begin
                    mem_write_enable = 1'b1;
                    mem_wdata        = cur_wdata;
                    state_next       = RESP;
                end else begin
                    // Loads and sub-word stores both need the current word.
                    mem_read_enable = 1'b1;
                    capture         = 1'b1;
                    state_next      = cur_write ? MERGE : RESP;
                end
            end
            MERGE: begin
                mem_write_enable = 1'b1;
                mem_wdata        = merge_data;
                state_next       = RESP;
            end
            RESP: begin
                p0_resp_valid = !cur_port;
                p1_resp_valid = cur_port;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Reset silences every strobe at once, so an aborted merge never writes.
        if (reset) begin
            mem_read_enable  = 1'b0;
            mem_write_enable = 1'b0;
            mem_wdata        = '0;
            p0_resp_valid    = 1'b0;
            p1_resp_valid    = 1'b0;
        end
    end

    assign resp_data     = (cur_write || cur_error) ? 32'd0 : load_data;
    assign p0_resp_rdata = p0_resp_valid ? resp_data : 32'd0;
    assign p1_resp_rdata = p1_resp_valid ? resp_data : 32'd0;
    assign p0_resp_error = p0_resp_valid && cur_error;
    assign p1_resp_error = p1_resp_valid && cur_error;

    assign mem_func3 = F3_W;
    assign mem_addr  = reset ? 32'd0 : {cur_addr[31:2], 2'b00};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions against a
// word-memory model, plus hand-written arbitration and reset-abort sequences.
module tb_mem_port_arbiter;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req_valid = 0, p0_req_write = 0, p1_req_valid = 0, p1_req_write = 0;
    logic [2:0]  p0_req_func3 = 0, p1_req_func3 = 0;
    logic [31:0] p0_req_addr = 0, p0_req_wdata = 0, p1_req_addr = 0, p1_req_wdata = 0;
    logic        p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid;
    logic [31:0] p0_resp_rdata, p1_resp_rdata;
    logic        p0_resp_error, p1_resp_error;
    logic        mem_read_enable, mem_write_enable;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;

    logic [31:0] mem [0:63];

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
        .p0_req_func3(p0_req_func3), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata), .p0_resp_error(p0_resp_error),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
        .p1_req_func3(p1_req_func3), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata), .p1_resp_error(p1_resp_error),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_func3(mem_func3), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clock) begin
        if (mem_write_enable) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_write_enable) wr_cnt <= wr_cnt + 1;
        if (mem_read_enable) rd_cnt <= rd_cnt + 1;
        if (mem_read_enable && mem_write_enable) both_cnt <= both_cnt + 1;
        if (p0_resp_valid || p1_resp_valid) resp_cnt <= resp_cnt + 1;
    end

    typedef struct {
        bit          port;
        bit          write;
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          error;
        int          lat;
        int          nrd;
        int          nwr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit port, bit write, logic [2:0] func3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, bit error,
                                int lat, int nrd, int nwr);
        vec_t t;
        t.port = port; t.write = write; t.func3 = func3; t.addr = addr; t.wdata = wdata;
        t.rdata = rdata; t.error = error; t.lat = lat; t.nrd = nrd; t.nwr = nwr;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit port, input logic valid, input logic write,
                         input logic [2:0] func3, input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req_valid = valid; p1_req_write = write; p1_req_func3 = func3;
            p1_req_addr = addr; p1_req_wdata = wdata;
        end else begin
            p0_req_valid = valid; p0_req_write = write; p0_req_func3 = func3;
            p0_req_addr = addr; p0_req_wdata = wdata;
        end
    endtask

    function automatic logic ready_of(input bit port);
        return port ? p1_req_ready : p0_req_ready;
    endfunction

    function automatic logic resp_of(input bit port);
        return port ? p1_resp_valid : p0_resp_valid;
    endfunction

    // One complete transaction: accept, then measure latency, data, error and strobes.
    task automatic do_req(input int idx, input vec_t t);
        int n, lat, rd0, wr0;
        @(negedge clock);
        drive(t.port, 1'b1, t.write, t.func3, t.addr, t.wdata);
        #1;
        n = 0;
        while (!ready_of(t.port) && n < 20) begin
            @(negedge clock); #1; n++;
        end
        check($sformatf("vec%0d ready", idx), {31'd0, ready_of(t.port)}, 32'd1);
        if (!ready_of(t.port)) begin
            drive(t.port, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            return;
        end
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clock);
        @(negedge clock);
        drive(t.port, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        lat = 1;
        while (!resp_of(t.port) && lat < 8) begin
            @(negedge clock); #1; lat++;
        end
        check($sformatf("vec%0d latency", idx), lat, t.lat);
        check($sformatf("vec%0d rdata", idx), t.port ? p1_resp_rdata : p0_resp_rdata, t.rdata);
        check($sformatf("vec%0d error", idx), {31'd0, t.port ? p1_resp_error : p0_resp_error},
              {31'd0, t.error});
        check($sformatf("vec%0d other_resp", idx), {31'd0, resp_of(!t.port)}, 32'd0);
        check($sformatf("vec%0d reads", idx), rd_cnt - rd0, t.nrd);
        check($sformatf("vec%0d writes", idx), wr_cnt - wr0, t.nwr);
        @(negedge clock); #1;
        check($sformatf("vec%0d resp_pulse", idx), {31'd0, resp_of(t.port)}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, wr0, resp0;
        int exp_grant[10];
        exp_grant = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // port, write, func3, addr, wdata, rdata, error, latency, reads, writes
        vecs.push_back(mk(0, 1, SW,     32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1));
        vecs.push_back(mk(0, 0, LW,     32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0));
        vecs.push_back(mk(1, 1, SW,     32'h10, 32'h11223344, 32'h0,        0, 2, 0, 1));
        vecs.push_back(mk(1, 1, SB,     32'h11, 32'h000000AA, 32'h0,        0, 3, 1, 1));
        vecs.push_back(mk(0, 0, LW,     32'h10, 32'h0,        32'h1122AA44, 0, 2, 1, 0));
        vecs.push_back(mk(1, 0, LB,     32'h11, 32'h0,        32'hFFFFFFAA, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, LBU,    32'h11, 32'h0,        32'h000000AA, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, SH,     32'h12, 32'hFFFF8001, 32'h0,        0, 3, 1, 1));
        vecs.push_back(mk(1, 0, LH,     32'h12, 32'h0,        32'hFFFF8001, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, LHU,    32'h12, 32'h0,        32'h00008001, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, LB,     32'h13, 32'h0,        32'hFFFFFF80, 0, 2, 1, 0));
        vecs.push_back(mk(1, 0, LBU,    32'h10, 32'h0,        32'h00000044, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, LB,     32'h12, 32'h0,        32'h00000001, 0, 2, 1, 0));
        vecs.push_back(mk(1, 0, LH,     32'h10, 32'h0,        32'hFFFFAA44, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, LH,     32'h13, 32'h0,        32'h0,        1, 2, 0, 0));
        vecs.push_back(mk(0, 1, SW,     32'h00, 32'h0BADF00D, 32'h0,        0, 2, 0, 1));
        vecs.push_back(mk(1, 1, SW,     32'h02, 32'hCAFEF00D, 32'h0,        1, 2, 0, 0));
        vecs.push_back(mk(0, 0, LW,     32'h00, 32'h0,        32'h0BADF00D, 0, 2, 1, 0));
        vecs.push_back(mk(1, 0, 3'b011, 32'h10, 32'h0,        32'h8001AA44, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 3'b111, 32'h11, 32'h0,        32'h0,        1, 2, 0, 0));
        vecs.push_back(mk(0, 1, 3'b100, 32'h04, 32'h13579BDF, 32'h0,        0, 2, 0, 1));
        vecs.push_back(mk(1, 1, SB,     32'h07, 32'h12345678, 32'h0,        0, 3, 1, 1));
        vecs.push_back(mk(1, 0, LW,     32'h04, 32'h0,        32'h78579BDF, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, SW,     32'h20, 32'h55667788, 32'h0,        0, 2, 0, 1));
        vecs.push_back(mk(1, 0, LH,     32'h11, 32'h0,        32'h0,        1, 2, 0, 0));

        // Reset with a request pending: everything but mem_func3 must stay low.
        drive(0, 1'b1, 1'b0, LW, 32'h10, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        check("reset_outputs",
              {24'd0, p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid,
               mem_read_enable, mem_write_enable, p0_resp_error, p1_resp_error}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_rdata", p0_resp_rdata | p1_resp_rdata, 32'd0);
        check("reset_mem_func3", {29'd0, mem_func3}, 32'd2);
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) do_req(i, vecs[i]);

        // Both ports continuously valid: port 1 gets every fifth grant.
        @(negedge clock);
        drive(0, 1'b1, 1'b0, LW, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, LW, 32'h10, 32'h0);
        for (int g = 0; g < 10; g++) begin
            #1;
            n = 0;
            while (!(p0_req_ready || p1_req_ready) && n < 20) begin
                @(negedge clock); #1; n++;
            end
            check($sformatf("grant%0d", g), {30'd0, p1_req_ready, p0_req_ready},
                  exp_grant[g] == 1 ? 32'd2 : 32'd1);
            @(negedge clock);
        end
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (5) @(negedge clock);

        // SH 0x20 aborted by reset while in MERGE.
        drive(0, 1'b1, 1'b1, SH, 32'h20, 32'h00001234);
        #1;
        check("abort_accept", {31'd0, p0_req_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        check("abort_access_read", {31'd0, mem_read_enable}, 32'd1);
        @(negedge clock); #1;
        check("abort_merge_write", {31'd0, mem_write_enable}, 32'd1);
        wr0 = wr_cnt;
        resp0 = resp_cnt;
        reset = 1'b1;
        #1;
        check("abort_write_gated", {31'd0, mem_write_enable}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        drive(1, 1'b1, 1'b0, LW, 32'h20, 32'h0);
        #1;
        check("abort_no_write", wr_cnt - wr0, 32'd0);
        check("abort_ready_next", {31'd0, p1_req_ready}, 32'd1);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clock);
        check("abort_no_resp", resp_cnt - resp0, 32'd0);
        do_req(100, mk(1, 0, LW, 32'h20, 32'h0, 32'h55667788, 0, 2, 1, 0));

        check("strobe_overlap", both_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
